pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Owns the OTTER program counter and drives instruction fetch. Holds PC, requests the
//  word at PC from instruction memory (req/ack), and presents the word to decode via
//  valid/ready. It is the consumer of next-PC selection: on REDIRECT, REDIRECT_SEL picks
//  JALR/BRANCH/JAL target, otherwise PC advances by 4. Misaligned targets raise a sticky fault.
// PARAMETERS
//  RESET_VEC    32'h0000_0000  PC value loaded on reset
//  CHECK_ALIGN  1              1: target with addr[1:0]!=0 faults; 0: bits [1:0] forced to 0
// PORTS
//  CLK           in   1   clock, all state updates on rising edge
//  RST_N         in   1   asynchronous reset, active-low
//  REDIRECT      in   1   take REDIRECT_SEL target this cycle
//  REDIRECT_SEL  in   2   0=PC+4 (no-op), 1=JALR_ADDR, 2=BRANCH_ADDR, 3=JAL_ADDR
//  JALR_ADDR     in   32  jalr target
//  BRANCH_ADDR   in   32  branch target
//  JAL_ADDR      in   32  jal target
//  IMEM_REQ      out  1   fetch request; held until IMEM_ACK
//  IMEM_ADDR     out  32  fetch address; stable while IMEM_REQ=1 and !IMEM_ACK
//  IMEM_ACK      in   1   request complete; IMEM_RDATA valid this cycle
//  IMEM_RDATA    in   32  fetched word
//  INSTR_VALID   out  1   INSTR/INSTR_PC/INSTR_PC4 valid
//  INSTR_READY   in   1   decode accepts instruction
//  INSTR         out  32  instruction word
//  INSTR_PC      out  32  address of INSTR
//  INSTR_PC4     out  32  INSTR_PC+4 (mod 2^32)
//  FAULT         out  1   sticky misaligned-target fault
// BEHAVIOUR
//  Reset (RST_N=0, async): state=RST, PC=RESET_VEC, pend=0, discard=0, FAULT=0,
//   IMEM_REQ=0, INSTR_VALID=0, INSTR/INSTR_PC/INSTR_PC4=0, IMEM_ADDR=RESET_VEC.
//   Reset mid-transaction abandons it; IMEM_REQ drops immediately.
//  States: RST -> FETCH (unconditional, 1 cycle); FETCH; HOLD; HALT.
//  Target T = mux(REDIRECT_SEL) when REDIRECT=1; REDIRECT with SEL=0 is ignored (no-op).
//  FETCH: IMEM_REQ=1, IMEM_ADDR=PC (registered, never changes before ACK).
//   - ACK, no REDIRECT, discard=0: INSTR<=RDATA, INSTR_PC<=PC, INSTR_PC4<=PC+4,
//     PC<=PC+4, -> HOLD. Latency req-to-INSTR_VALID = ACK cycle + 1.
//   - ACK with REDIRECT: data dropped, PC<=T, stay FETCH (new req next cycle).
//   - ACK with discard=1 (no new REDIRECT): data dropped, PC<=pend target, discard<=0.
//   - REDIRECT without ACK: pend target<=T, discard<=1; IMEM_ADDR unchanged.
//     Later REDIRECT before ACK overwrites pend target (last wins).
//  HOLD: INSTR_VALID=1, outputs stable until handshake.
//   - READY, no REDIRECT: -> FETCH at PC (already +4). One bubble between fetches.
//   - REDIRECT (READY or not): held instruction squashed, PC<=T, -> FETCH; a handshake in
//     the redirect cycle is void (decode flushes its own side).
//  Fault: REDIRECT with CHECK_ALIGN=1 and T[1:0]!=0. FAULT=1 next cycle, stays until reset.
//   From HOLD: -> HALT. From FETCH: finish outstanding handshake (discard data), -> HALT.
//   HALT: IMEM_REQ=0, INSTR_VALID=0, inputs ignored. CHECK_ALIGN=0: T[1:0] zeroed, no fault.
//  Arithmetic: PC+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000, no flag.
//  At most one memory request outstanding; IMEM_ACK outside FETCH is ignored.
// TESTING
//  1 Reset RESET_VEC=0x100, ACK after 2 cycles, READY=1 -> IMEM_ADDR 0x100,0x104,0x108;
//    INSTR_PC matches, INSTR_PC4=INSTR_PC+4.
//  2 HOLD at 0x200, READY=0 for 5 cycles -> INSTR/INSTR_PC stable; READY=1 -> next req 0x204.
//  3 FETCH 0x300 pending, REDIRECT SEL=3 JAL_ADDR=0x400 while no ACK -> IMEM_ADDR stays
//    0x300 until ACK, data dropped, next req 0x400, no INSTR_VALID for 0x300.
//  4 REDIRECT SEL=2 BRANCH_ADDR=0x502 -> FAULT=1 next cycle, REQ=0 after pending ACK,
//    INSTR_VALID=0; remains until RST_N=0.
//  5 PC=0xFFFF_FFFC fetched, accepted -> next IMEM_ADDR=0x0, INSTR_PC4=0x0.
//  6 RST_N low mid-FETCH (REQ=1, no ACK) -> REQ=0 same cycle; after release req at RESET_VEC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
`default_nettype none
//============================================================================
// Module      : pc_fetch_unit
// Description : OTTER program-counter owner and instruction-fetch front end.
//               Holds the PC, issues one instruction-memory request at a time
//               (req/ack), and presents each fetched word to decode through a
//               valid/ready handshake. Redirects select the JALR/BRANCH/JAL
//               target; otherwise the PC advances by 4. A misaligned target
//               raises a sticky fault and halts fetch.
// Ports       : clk, rst_n                      clock, async active-low reset
//               redirect, redirect_sel          next-PC override and selector
//               jalr_addr/branch_addr/jal_addr  candidate targets
//               imem_req/imem_addr/imem_ack/imem_rdata  memory request port
//               instr_valid/instr_ready         decode handshake
//               instr/instr_pc/instr_pc4        delivered instruction bundle
//               fault                           sticky misaligned-target flag
// Revision    : 1.0  initial release
//============================================================================
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [1:0]  redirect_sel,
    input  logic [31:0] jalr_addr,
    input  logic [31:0] branch_addr,
    input  logic [31:0] jal_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc4,
    output logic        fault
);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t      r_state,     w_state_nxt;
    logic [31:0] r_pc,        w_pc_nxt;
    logic [31:0] r_pend,      w_pend_nxt;
    logic        r_discard,   w_discard_nxt;
    logic        r_fault,     w_fault_nxt;
    logic [31:0] r_instr,     w_instr_nxt;
    logic [31:0] r_instr_pc,  w_instr_pc_nxt;
    logic [31:0] r_instr_pc4, w_instr_pc4_nxt;

    logic [31:0] w_raw_target;
    logic [31:0] w_target;
    logic        w_redir;
    logic        w_misalign;
    logic [31:0] w_pc_plus4;

    // Target selection; selector 0 means "no redirect" so its value is unused.
    always_comb begin
        w_raw_target = 32'h0000_0000;
        case (redirect_sel)
            2'd1:    w_raw_target = jalr_addr;
            2'd2:    w_raw_target = branch_addr;
            2'd3:    w_raw_target = jal_addr;
            default: w_raw_target = 32'h0000_0000;
        endcase
    end

    // With alignment checking disabled the low bits are simply dropped.
    assign w_target   = CHECK_ALIGN ? w_raw_target : {w_raw_target[31:2], 2'b00};
    assign w_redir    = redirect && (redirect_sel != 2'd0);
    assign w_misalign = CHECK_ALIGN && (w_raw_target[1:0] != 2'b00);
    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RST;
            r_pc        <= RESET_VEC;
            r_pend      <= 32'h0000_0000;
            r_discard   <= 1'b0;
            r_fault     <= 1'b0;
            r_instr     <= 32'h0000_0000;
            r_instr_pc  <= 32'h0000_0000;
            r_instr_pc4 <= 32'h0000_0000;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_pend      <= w_pend_nxt;
            r_discard   <= w_discard_nxt;
            r_fault     <= w_fault_nxt;
            r_instr     <= w_instr_nxt;
            r_instr_pc  <= w_instr_pc_nxt;
            r_instr_pc4 <= w_instr_pc4_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_pend_nxt      = r_pend;
        w_discard_nxt   = r_discard;
        w_fault_nxt     = r_fault;
        w_instr_nxt     = r_instr;
        w_instr_pc_nxt  = r_instr_pc;
        w_instr_pc4_nxt = r_instr_pc4;

        case (r_state)
            ST_RST: begin
                w_state_nxt = ST_FETCH;
            end

            ST_FETCH: begin
                if (r_fault) begin
                    // Faulted with a request still open: let memory finish, then stop.
                    if (imem_ack) begin
                        w_state_nxt = ST_HALT;
                    end
                end else if (w_redir && w_misalign) begin
                    w_fault_nxt   = 1'b1;
                    w_discard_nxt = 1'b0;
                    if (imem_ack) begin
                        w_state_nxt = ST_HALT;
                    end
                end else if (imem_ack) begin
                    if (w_redir) begin
                        w_pc_nxt      = w_target;
                        w_discard_nxt = 1'b0;
                    end else if (r_discard) begin
                        w_pc_nxt      = r_pend;
                        w_discard_nxt = 1'b0;
                    end else begin
                        w_instr_nxt     = imem_rdata;
                        w_instr_pc_nxt  = r_pc;
                        w_instr_pc4_nxt = w_pc_plus4;
                        w_pc_nxt        = w_pc_plus4;
                        w_state_nxt     = ST_HOLD;
                    end
                end else if (w_redir) begin
                    // The address must stay put until ack, so park the target.
                    w_pend_nxt    = w_target;
                    w_discard_nxt = 1'b1;
                end
            end

            ST_HOLD: begin
                if (w_redir && w_misalign) begin
                    w_fault_nxt = 1'b1;
                    w_state_nxt = ST_HALT;
                end else if (w_redir) begin
                    // Redirect wins over a same-cycle handshake.
                    w_pc_nxt    = w_target;
                    w_state_nxt = ST_FETCH;
                end else if (instr_ready) begin
                    w_state_nxt = ST_FETCH;
                end
            end

            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end

            default: begin
                w_state_nxt = ST_RST;
            end
        endcase
    end

    assign imem_req    = (r_state == ST_FETCH);
    assign imem_addr   = r_pc;
    assign instr_valid = (r_state == ST_HOLD);
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_pc4   = r_instr_pc4;
    assign fault       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
//============================================================================
// Module      : tb_pc_fetch_unit
// Description : Directed self-checking bench for pc_fetch_unit
//               (RESET_VEC = 0x100, CHECK_ALIGN = 1).
// Revision    : 1.0  initial release
//============================================================================
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [1:0]  redirect_sel;
    logic [31:0] jalr_addr;
    logic [31:0] branch_addr;
    logic [31:0] jal_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc4;
    logic        fault;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .RESET_VEC   (32'h0000_0100),
        .CHECK_ALIGN (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .redirect     (redirect),
        .redirect_sel (redirect_sel),
        .jalr_addr    (jalr_addr),
        .branch_addr  (branch_addr),
        .jal_addr     (jal_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_pc4    (instr_pc4),
        .fault        (fault)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    // One-cycle memory acknowledge carrying the word for the current address.
    task automatic ack_now();
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redirect = 1'b0; redirect_sel = 2'd0;
        jalr_addr = 32'h0; branch_addr = 32'h0; jal_addr = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
        tick(); tick();
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl req=%b valid=%b fault=%b required 0/0/0", imem_req, instr_valid, fault);
        end
        checks++;
        if (imem_addr !== 32'h100) begin
            failures++;
            $display("FAIL reset_addr got=%h required=00000100", imem_addr);
        end
        checks++;
        if (instr !== 32'h0 || instr_pc !== 32'h0 || instr_pc4 !== 32'h0) begin
            failures++;
            $display("FAIL reset_instr got=%h/%h/%h required all 0", instr, instr_pc, instr_pc4);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            failures++;
            $display("FAIL first_req req=%b addr=%h required 1/00000100", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp;
        instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp = 32'h100 + 32'(4 * k);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp) begin
                failures++;
                $display("FAIL seq_req%0d req=%b addr=%h required 1/%h", k, imem_req, imem_addr, exp);
            end
            for (int s = 0; s < 2; s++) begin
                tick();
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== exp || instr_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL seq_stall%0d req=%b addr=%h valid=%b required 1/%h/0", k, imem_req, imem_addr, instr_valid, exp);
                end
            end
            ack_now();
            checks++;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== mem_word(exp) ||
                instr_pc !== exp || instr_pc4 !== exp + 32'd4) begin
                failures++;
                $display("FAIL seq_deliver%0d valid=%b req=%b instr=%h pc=%h pc4=%h required 1/0/%h/%h/%h",
                         k, instr_valid, imem_req, instr, instr_pc, instr_pc4, mem_word(exp), exp, exp + 32'd4);
            end
            tick();
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_hold_stall();
        ack_now();                         // fetch at 0x10C lands in HOLD
        redirect = 1'b1; redirect_sel = 2'd1; jalr_addr = 32'h200;
        tick();
        redirect = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_redirect req=%b addr=%h valid=%b required 1/00000200/0", imem_req, imem_addr, instr_valid);
        end
        ack_now();
        for (int s = 0; s < 5; s++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr !== mem_word(32'h200) || instr_pc !== 32'h200) begin
                failures++;
                $display("FAIL hold_stable%0d valid=%b instr=%h pc=%h required 1/%h/00000200", s, instr_valid, instr, instr_pc, mem_word(32'h200));
            end
            tick();
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h204 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_next req=%b addr=%h valid=%b required 1/00000204/0", imem_req, imem_addr, instr_valid);
        end
    endtask

    task automatic test_redirect_pending();
        // Redirect in the same cycle as ack: data dropped, target taken directly.
        imem_ack = 1'b1; imem_rdata = mem_word(32'h204);
        redirect = 1'b1; redirect_sel = 2'd1; jalr_addr = 32'h300;
        tick();
        imem_ack = 1'b0; redirect = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h300 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL ack_redirect req=%b addr=%h valid=%b required 1/00000300/0", imem_req, imem_addr, instr_valid);
        end
        // Two redirects before ack; the later one must win.
        redirect = 1'b1; redirect_sel = 2'd2; branch_addr = 32'h500;
        tick();
        redirect_sel = 2'd3; jal_addr = 32'h400;
        tick();
        redirect = 1'b0;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h300 || instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL pend_stable%0d req=%b addr=%h valid=%b required 1/00000300/0", s, imem_req, imem_addr, instr_valid);
            end
            tick();
        end
        ack_now();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h400 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL pend_target req=%b addr=%h valid=%b required 1/00000400/0", imem_req, imem_addr, instr_valid);
        end
        ack_now();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h400 || instr !== mem_word(32'h400)) begin
            failures++;
            $display("FAIL pend_deliver valid=%b pc=%h instr=%h required 1/00000400/%h", instr_valid, instr_pc, instr, mem_word(32'h400));
        end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_sel = 2'd3; jal_addr = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_req req=%b addr=%h required 1/fffffffc", imem_req, imem_addr);
        end
        ack_now();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC || instr_pc4 !== 32'h0) begin
            failures++;
            $display("FAIL wrap_pc4 valid=%b pc=%h pc4=%h required 1/fffffffc/00000000", instr_valid, instr_pc, instr_pc4);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL wrap_next req=%b addr=%h required 1/00000000", imem_req, imem_addr);
        end
        ack_now();
    endtask

    task automatic test_fault();
        // Selector 0 with redirect asserted is a no-op.
        redirect = 1'b1; redirect_sel = 2'd0; jal_addr = 32'h700;
        tick();
        redirect = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || fault !== 1'b0) begin
            failures++;
            $display("FAIL sel0_noop valid=%b pc=%h fault=%b required 1/00000000/0", instr_valid, instr_pc, fault);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        redirect = 1'b1; redirect_sel = 2'd2; branch_addr = 32'h502;
        tick();
        redirect = 1'b0;
        checks++;
        if (fault !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            failures++;
            $display("FAIL fault_pending fault=%b req=%b addr=%h required 1/1/00000004", fault, imem_req, imem_addr);
        end
        tick();
        ack_now();
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fault !== 1'b1) begin
            failures++;
            $display("FAIL fault_halt req=%b valid=%b fault=%b required 0/0/1", imem_req, instr_valid, fault);
        end
        redirect = 1'b1; redirect_sel = 2'd3; jal_addr = 32'h600;
        imem_ack = 1'b1; instr_ready = 1'b1;
        tick(); tick(); tick();
        redirect = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fault !== 1'b1) begin
            failures++;
            $display("FAIL fault_sticky req=%b valid=%b fault=%b required 0/0/1", imem_req, instr_valid, fault);
        end
    endtask

    task automatic test_reset_mid_fetch();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 || fault !== 1'b0) begin
            failures++;
            $display("FAIL rst_clear req=%b addr=%h fault=%b required 1/00000100/0", imem_req, imem_addr, fault);
        end
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h100) begin
            failures++;
            $display("FAIL rst_async req=%b addr=%h required 0/00000100", imem_req, imem_addr);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            failures++;
            $display("FAIL rst_restart req=%b addr=%h required 1/00000100", imem_req, imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_hold_stall();
        test_redirect_pending();
        test_wrap();
        test_fault();
        test_reset_mid_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
